// File: rtl/vsmac_pkg.sv
// Shared types and helpers for the vsmac_stream vector-scalar MAC datapath.
package vsmac_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_FIN = 1'b1
  } state_e;

  // Narrowest accumulator that holds ACCUMULATIONS full-width products without wrap.
  function automatic int min_acc_width(input int width, input int accumulations);
    return 2 * width + $clog2(accumulations);
  endfunction

  // Clamp a signed value to the range of an out_width-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int out_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/vsmac_lane.sv
// One lane: signed multiply, wide accumulate, then shift / ReLU / saturate.
module vsmac_lane
  import vsmac_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        acc_en_i,
  input  logic                        clear_i,
  input  logic signed [WIDTH-1:0]     a_i,
  input  logic signed [WIDTH-1:0]     b_i,
  input  logic                        relu_i,
  output logic signed [OUT_WIDTH-1:0] post_o
);

  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] rectified;

  assign prod = (2 * WIDTH)'(a_i) * (2 * WIDTH)'(b_i);

  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (acc_en_i) acc_d = (clear_i ? '0 : acc_q) + ACC_WIDTH'(prod);
  end

  // NOTE: the accumulator is reset explicitly so an aborted group can never leak into the next one.
  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign shifted = acc_q >>> FRAC_SHIFT;

  always_comb begin
    rectified = shifted;
    if (relu_i && (shifted < 0)) rectified = '0;
    post_o = OUT_WIDTH'(sat_signed(64'(rectified), OUT_WIDTH));
  end

endmodule

// File: rtl/vsmac_stream.sv
// Streaming vector-scalar MAC: SIZE lanes accumulate ACCUMULATIONS beats, then emit one result.
module vsmac_stream
  import vsmac_pkg::*;
#(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACC_WIDTH     = 20,
  parameter int OUT_WIDTH     = 8,
  parameter int ACCUMULATIONS = 3,
  parameter int FRAC_SHIFT    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*SIZE-1:0]     a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH*SIZE-1:0] out
);

  localparam int CNT_W = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCUMULATIONS - 1);

  generate
    if (ACC_WIDTH < min_acc_width(WIDTH, ACCUMULATIONS) || ACC_WIDTH > 64) begin : g_bad_acc_width
      $error("vsmac_stream: ACC_WIDTH out of range for WIDTH/ACCUMULATIONS");
    end
  endgenerate

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      relu_q, relu_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_WIDTH*SIZE-1:0] out_q, out_d;
  logic [OUT_WIDTH*SIZE-1:0] post_w;
  logic                      accept;
  logic                      first_beat;
  logic                      load;

  assign accept     = in_valid && in_ready;
  assign first_beat = (count_q == '0);
  // A finished group moves to the output register whenever that register is free or draining.
  assign load       = (state_q == ST_FIN) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    in_ready    = (state_q == ST_ACC);
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (first_beat) relu_d = relu_en;
          if (count_q == LAST_CNT) state_d = ST_FIN;
          else                     count_d = count_q + 1'b1;
        end
      end
      ST_FIN: begin
        if (load) begin
          state_d = ST_ACC;
          count_d = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
    if (load) begin
      out_d       = post_w;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    vsmac_lane #(
      .WIDTH      (WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .acc_en_i (accept),
      .clear_i  (first_beat),
      .a_i      (a[WIDTH*g +: WIDTH]),
      .b_i      (b),
      .relu_i   (relu_q),
      .post_o   (post_w[OUT_WIDTH*g +: OUT_WIDTH])
    );
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
